// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational Multi_Alu among NUM_REQ lane requesters.
// Optional build macro ALU_ARB_PRIO0_EN gives requester 0 fixed absolute priority.
module alu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*SEL_W-1:0]  req_sel,
    output logic [NUM_REQ-1:0]        resp_valid,
    input  logic [NUM_REQ-1:0]        resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic                      resp_err,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [SEL_W-1:0]          alu_select,
    input  logic [DATA_W-1:0]         alu_result
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    logic [IDX_W-1:0]   ptr_r;
    logic [IDX_W-1:0]   gnt_r;
    logic [IDX_W-1:0]   gnt_idx_s;
    logic [IDX_W-1:0]   cand_s;
    logic               any_s;
    logic               hit_s;

    // Select codes the ALU implements; anything else is flagged as an error.
    function automatic logic sel_supported(input logic [SEL_W-1:0] sel);
        logic ok;
        case (sel)
            SEL_W'(0), SEL_W'(1), SEL_W'(2), SEL_W'(5): ok = 1'b1;
            default:                                     ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v[i] = (IDX_W'(i) == idx);
        end
        return v;
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        any_s     = 1'b0;
        hit_s     = 1'b0;
        cand_s    = '0;
        gnt_idx_s = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s    = IDX_W'((int'(ptr_r) + k) % NUM_REQ);
            hit_s     = !any_s && req_valid[cand_s];
            gnt_idx_s = hit_s ? cand_s : gnt_idx_s;
            any_s     = any_s | hit_s;
        end
`ifdef ALU_ARB_PRIO0_EN
        // Requester 0 overrides the rotation whenever it asks.
        if (req_valid[0]) begin
            any_s     = 1'b1;
            gnt_idx_s = '0;
        end else begin
            gnt_idx_s = gnt_idx_s;
        end
`endif
    end

    // Grant handshake is combinational in IDLE and suppressed while in reset.
    always_comb begin
        if ((state_r == IDLE) && any_s && rst_n) begin
            req_ready = one_hot(gnt_idx_s);
        end else begin
            req_ready = '0;
        end
    end

    // Response valid is decoded from the state and the registered grant.
    always_comb begin
        if (state_r == RESP) begin
            resp_valid = one_hot(gnt_r);
        end else begin
            resp_valid = '0;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (any_s) begin
                    state_next_s = EXEC;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EXEC: state_next_s = RESP;
            RESP: begin
                if (resp_ready[gnt_r]) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture on grant, result capture at the end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r      <= IDX_W'(NUM_REQ - 1);
            gnt_r      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_select <= '0;
            resp_data  <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        alu_a      <= req_a[int'(gnt_idx_s)*DATA_W +: DATA_W];
                        alu_b      <= req_b[int'(gnt_idx_s)*DATA_W +: DATA_W];
                        alu_select <= req_sel[int'(gnt_idx_s)*SEL_W +: SEL_W];
                        gnt_r      <= gnt_idx_s;
`ifdef ALU_ARB_PRIO0_EN
                        if (gnt_idx_s != '0) begin
                            ptr_r <= gnt_idx_s;
                        end
`else
                        ptr_r      <= gnt_idx_s;
`endif
                    end
                end
                EXEC: begin
                    resp_data <= alu_result;
                    resp_err  <= !sel_supported(alu_select);
                end
                default: begin
                    resp_data <= resp_data;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter; includes a behavioural Multi_Alu model on the ALU side.
module tb_alu_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N-1:0]      req_ready;
    logic [N*DW-1:0]   req_a = '0;
    logic [N*DW-1:0]   req_b = '0;
    logic [N*SW-1:0]   req_sel = '0;
    logic [N-1:0]      resp_valid;
    logic [N-1:0]      resp_ready = 4'hF;
    logic [DW-1:0]     resp_data;
    logic              resp_err;
    logic [DW-1:0]     alu_a;
    logic [DW-1:0]     alu_b;
    logic [SW-1:0]     alu_select;
    logic [DW-1:0]     alu_result;

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   cyc       = 0;

    alu_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .SEL_W(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_select(alu_select),
        .alu_result(alu_result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multi_Alu model: add, sub, mul, carry-less (GF) multiply; xor for unsupported codes.
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] s);
        logic [31:0] r;
        case (s)
            3'd0: r = a + b;
            3'd1: r = a - b;
            3'd2: r = a * b;
            3'd5: begin
                r = 32'd0;
                for (int i = 0; i < 32; i++) if (b[i]) r = r ^ (a << i);
            end
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    assign alu_result = alu_model(alu_a, alu_b, alu_select);

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", nm, act, expv);
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] s);
        req_a[i*DW +: DW]   = a;
        req_b[i*DW +: DW]   = b;
        req_sel[i*SW +: SW] = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a grant; returns its index at the sampling negedge, -1 on timeout.
    task automatic wait_grant(output int g, output int at_cyc);
        g = -1;
        at_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) begin
                at_cyc = cyc;
                for (int i = 0; i < N; i++) if (req_ready[i]) g = i;
                check("grant_onehot", 64'($onehot(req_ready)), 64'd1);
                break;
            end
        end
        if (g < 0) check("grant_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        step();
    endtask

    // Monitor: pops the scoreboard on every completed response handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && ((resp_valid & resp_ready) != '0)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 64'(resp_valid), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("resp_valid", 64'(resp_valid), 64'(4'b0001 << e.idx));
                check("resp_data", 64'(resp_data), 64'(e.data));
                check("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int gc;
        int prev_gc;
        int exp_g[4];

        // Reset state, with a request pending to confirm req_ready stays low.
        req_valid = 4'b0001;
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_outputs", {resp_valid, resp_err, resp_data, 1'b0}, 64'd0);
        check("rst_alu", {alu_select, alu_a, alu_b[28:0]}, 64'd0);
        req_valid = '0;

        // Single op: grant same cycle, ALU operands next cycle, response after 2 cycles.
        step();
        rst_n = 1'b1;
        set_req(0, 32'd1, 32'd1, 3'd0);
        req_valid = 4'b0001;
        exp_q.push_back('{2'd0, 32'h0000_0002, 1'b0});
        @(negedge clk);
        check("t1_req_ready", 64'(req_ready), 64'b0001);
        step();
        req_valid = '0;
        @(negedge clk);
        check("t1_alu_a", 64'(alu_a), 64'd1);
        check("t1_alu_b", 64'(alu_b), 64'd1);
        check("t1_exec_no_valid", 64'(resp_valid), 64'd0);
        step();
        @(negedge clk);
        check("t1_latency", 64'(resp_valid), 64'b0001);
        drain();

        // All four requesters: grants 0,1,2,3 spaced 3 cycles apart.
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_req(i, 32'd5, 32'd3, 3'd1);
            exp_q.push_back('{2'(i), 32'h0000_0002, 1'b0});
        end
        req_valid = 4'b1111;
        prev_gc = 0;
        for (int i = 0; i < N; i++) begin
            wait_grant(g, gc);
            check("t2_order", 64'(g), 64'(i));
            if (i > 0) check("t2_interval", 64'(gc - prev_gc), 64'd3);
            prev_gc = gc;
            step();
            if (g >= 0) req_valid[g] = 1'b0;
        end
        drain();

        // Stall on requester 1 with others' resp_ready high; req0 waits pending.
        resp_ready = 4'b1101;
        set_req(1, 32'd2, 32'd3, 3'd2);
        req_valid = 4'b0010;
        exp_q.push_back('{2'd1, 32'h0000_0006, 1'b0});
        wait_grant(g, gc);
        check("t3_grant", 64'(g), 64'd1);
        step();
        set_req(0, 32'd7, 32'd1, 3'd0);
        req_valid = 4'b0001;
        exp_q.push_back('{2'd0, 32'h0000_0008, 1'b0});
        step();
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(resp_valid), 64'b0010);
            check("t3_hold_data", 64'(resp_data), 64'h6);
            check("t3_no_ready", 64'(req_ready), 64'd0);
            step();
        end
        resp_ready = 4'b1111;
        wait_grant(g, gc);
        check("t3_pending_grant", 64'(g), 64'd0);
        step();
        req_valid = '0;
        drain();

        // GF multiply by one.
        set_req(2, 32'hA2AF_2F63, 32'h0000_0001, 3'd5);
        req_valid = 4'b0100;
        exp_q.push_back('{2'd2, 32'hA2AF_2F63, 1'b0});
        wait_grant(g, gc);
        check("t4_grant", 64'(g), 64'd2);
        step();
        req_valid = '0;
        drain();

        // Unsupported select flags resp_err; data is the ALU's raw output.
        set_req(3, 32'h0000_00F0, 32'h0000_000F, 3'd7);
        req_valid = 4'b1000;
        exp_q.push_back('{2'd3, 32'h0000_00FF, 1'b1});
        wait_grant(g, gc);
        check("t5_grant", 64'(g), 64'd3);
        step();
        req_valid = '0;
        drain();

        // Reset asserted during EXEC discards the op.
        set_req(0, 32'd1, 32'd1, 3'd0);
        req_valid = 4'b0001;
        wait_grant(g, gc);
        step();
        check("t5_exec_alu_a", 64'(alu_a), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_req_ready", 64'(req_ready), 64'd0);
        check("t5_rst_resp", {resp_valid, resp_err, resp_data}, 64'd0);
        check("t5_rst_alu", {alu_select, alu_a, alu_b[28:0]}, 64'd0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        for (int s = 0; s < 6; s++) begin
            @(negedge clk);
            check("t5_no_resp", 64'(resp_valid), 64'd0);
        end

        // req0 and req2 continuously valid.
        do_reset();
`ifdef ALU_ARB_PRIO0_EN
        exp_g = '{0, 0, 0, 0};
`else
        exp_g = '{0, 2, 0, 2};
`endif
        set_req(0, 32'd1, 32'd2, 3'd0);
        set_req(2, 32'd9, 32'd4, 3'd1);
        for (int i = 0; i < 4; i++) begin
            if (exp_g[i] == 0) exp_q.push_back('{2'd0, 32'h0000_0003, 1'b0});
            else               exp_q.push_back('{2'd2, 32'h0000_0005, 1'b0});
        end
        req_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            wait_grant(g, gc);
            check("t6_grant_seq", 64'(g), 64'(exp_g[i]));
            step();
            if (i == 3) req_valid = '0;
        end
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
- Shares one combinational Multi_Alu instance among NUM_REQ SIMD lane requesters in the AES datapath.
- Arbitrates requests round-robin, registers the operands and drives the ALU, then captures the result.
- Returns the result to the granted requester with a valid/ready handshake.
- Sits between the lane controllers and the single Multi_Alu instance.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_W, 32: operand and result width.
- SEL_W, 3: ALU select width.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational in IDLE.
- req_a  in  NUM_REQ*DATA_W  operand a; slice i belongs to requester i.
- req_b  in  NUM_REQ*DATA_W  operand b, packed the same way.
- req_sel  in  NUM_REQ*SEL_W  ALU select, packed the same way.
- resp_valid  out  NUM_REQ  one-hot response valid.
- resp_ready  in  NUM_REQ  per-requester response accept.
- resp_data  out  DATA_W  result for the requester flagged in resp_valid.
- resp_err  out  1  select code unsupported; qualified by any resp_valid.
- alu_a  out  DATA_W  to Multi_Alu a.
- alu_b  out  DATA_W  to Multi_Alu b.
- alu_select  out  SEL_W  to Multi_Alu select.
- alu_result  in  DATA_W  from Multi_Alu result_alu.

Behaviour:
- Reset values (rst_n low, asynchronous):
  - State = IDLE.
  - req_ready = 0, resp_valid = 0, resp_data = 0, resp_err = 0.
  - alu_a = 0, alu_b = 0, alu_select = 0.
  - Grant pointer = NUM_REQ-1, so requester 0 has first priority after reset.
- FSM states are IDLE, EXEC and RESP.
- IDLE:
  - If any req_valid is high, choose g = the first valid index searching from (ptr+1) mod NUM_REQ upward with wrap-around.
  - Assert req_ready[g] in that same cycle; this is the handshake.
  - On the clock edge: latch slices a/b/sel of g into operand registers, set ptr=g, go to EXEC.
  - If no req_valid is high: stay in IDLE and assert no req_ready.
- EXEC:
  - alu_a/alu_b/alu_select are driven from the operand registers. They are registered outputs, stable for the whole cycle.
  - At the end of the cycle: resp_data <= alu_result; resp_err <= (sel not in {000,001,010,101}); go to RESP.
  - Unsupported codes still pass through to the ALU; resp_data is whatever the ALU returns.
- RESP:
  - resp_valid[g]=1; resp_data and resp_err are held stable.
  - When resp_ready[g]=1: go to IDLE next cycle.
  - resp_ready of non-granted requesters is ignored.
  - No new grant is issued in RESP.
- Timing:
  - Latency, request accept to resp_valid: 2 cycles.
  - Minimum issue interval per op: 3 cycles.
- req_ready is 0 in EXEC and RESP, so a requester may hold req_valid high; it stays pending.
- A request dropped before being granted is simply not served; there is no error.
- Fairness: a continuously asserting requester waits at most NUM_REQ-1 other grants.
- alu_* outputs hold their last values outside EXEC; downstream treats them as don't-care.
- Reset mid-operation: everything returns to reset values immediately. An in-flight op is discarded and its response is never issued.
- resp_data and resp_err are registered; resp_valid is decoded from state plus the registered g.

Optional Feature:
- Macro: ALU_ARB_PRIO0_EN.
- When defined:
  - Requester 0 has fixed absolute priority: whenever req_valid[0] is high in IDLE it is granted.
  - The pointer is not updated on requester-0 grants.
  - The remaining requesters use round-robin among themselves, as above.
- When undefined: pure round-robin over all NUM_REQ requesters, exactly as in Behaviour.

Test Plan:
- Reset release, req0 valid, a=1, b=1, sel=000:
  - req_ready[0] high in the same cycle.
  - alu_a=1, alu_b=1 in the next cycle.
  - resp_valid[0]=1 two cycles after accept, resp_data=00000002, resp_err=0.
- Requesters 0..3 all valid, each with a=5, b=3, sel=001; resp_ready always 1:
  - Grants occur in order 0,1,2,3, one every 3 cycles.
  - Each resp_data=00000002.
- req1 a=2, b=3, sel=010; resp_ready[1] held low 4 cycles:
  - resp_valid[1] and resp_data=00000006 held stable for the whole stall.
  - req_ready stays 0 for all requesters until acceptance.
- req2 a=A2AF2F63, b=00000001, sel=101:
  - resp_data=A2AF2F63 (GF multiply by 1), resp_err=0.
- req3 sel=111:
  - resp_err=1 with resp_valid[3].
  - rst_n pulled low during EXEC of a subsequent op: all outputs are 0 asynchronously and no response is issued afterwards.
- With ALU_ARB_PRIO0_EN: req0 and req2 continuously valid:
  - req0 wins every arbitration and req2 is never granted while req0 stays valid.
  - Without the macro, grants alternate 0,2,0,2.
